uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serialises bytes onto the UART line as 8N1/8N2 frames (8E/8O with the parity option), LSB first.
//  Upstream neighbour of the UART receiver: in the loopback build, tx drives the receiver's rx input.
//  Byte-side interface is valid/ready, mirroring the receiver's rx_valid/rx_ready.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency in Hz
//  BAUD        115200      line rate; DIV = CLK_HZ/BAUD cycles per bit (integer divide)
//  STOP_BITS   1           number of stop bits, legal values 1 or 2
//  PARITY_ODD  0           1 = odd, 0 = even parity; used only when UART_TX_PARITY_EN is defined
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  tx_data   in   8  byte to send; sampled only on an accept cycle
//  tx_valid  in   1  upstream has a byte
//  tx_ready  out  1  block can accept; accept = tx_valid && tx_ready on a rising clk edge
//  tx        out  1  serial line, idles high
//  tx_busy   out  1  frame in progress (any state other than IDLE)
//  tx_done   out  1  one-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  - Reset (async, immediate): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, counters 0.
//  - Reset mid-frame: the line returns high at once; the partial frame is dropped, with no retry.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx=1, tx_ready=1. On accept, latch tx_data into the shift register and go to START.
//    tx_ready=0 from the next cycle.
//  - The start bit begins on the cycle after accept. Each bit holds tx for exactly DIV cycles.
//    A cycle counter runs 0..DIV-1; a bit ends when the counter reaches DIV-1.
//  - DATA: bit index 0..7, LSB first; the shift register shifts right at each bit end.
//  - STOP: tx=1 for STOP_BITS*DIV cycles. tx_done pulses in the final cycle of the stop period.
//    IDLE is entered on the next cycle.
//  - Frame length = (1+8+P+STOP_BITS)*DIV cycles, where P=1 with parity and 0 without.
//    At least one IDLE cycle separates frames: no back-to-back accept in the stop cycle.
//  - tx_data and tx_valid changes while busy are ignored. A tx_valid held high through a frame
//    is accepted exactly once more, in the first IDLE cycle.
//  - tx is a registered output: no combinational path from any input to tx.
//  - Elaboration-time checks: DIV >= 2; STOP_BITS in {1,2}. Fatal error otherwise.
// CONFIGURATION
//  - `UART_TX_PARITY_EN defined: one PARITY state after bit 7, held DIV cycles.
//    Bit value = ^latched_byte ^ PARITY_ODD, computed at accept time from the latched byte.
//  - `UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; PARITY_ODD is ignored.
// STRUCTURE
//  - uart_pkg: FSM state enum tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP},
//    plus the shared localparam function uart_div(CLK_HZ, BAUD) so TX and RX agree on DIV.
//  - One sub-module, uart_baud_tick: a free-running counter, restarted on accept, that emits
//    bit_end once per DIV cycles.
//  - uart_tx owns the FSM, the shift register, the bit index and stop-bit counting.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10 unless noted)
//  1. Accept 0x55 -> tx low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high.
//     tx_done pulses at cycle 100 after accept; tx_ready returns at cycle 101.
//  2. Loopback into the UART receiver: send 0xA5, 0x00, 0xFF -> receiver presents exactly those
//     bytes in order; no framing drops.
//  3. tx_valid held high with 0x3C, then 0xC3 -> exactly two frames, separated by 1 idle cycle.
//     tx_data changes mid-frame do not alter the frame on the line.
//  4. Assert rst_n low at cycle 45 of a 0x0F frame -> tx=1 and tx_busy=0 in the same cycle.
//     After release, a fresh accept of 0x81 produces a clean frame.
//  5. STOP_BITS=2, send 0xF0 -> tx high for 20 cycles after bit 7; frame is 110 cycles.
//  6. With UART_TX_PARITY_EN, PARITY_ODD=0: 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity 0.
//     Frame is 110 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and the bit-period divider
// that both the transmitter and the receiver derive from CLK_HZ and BAUD.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Clock cycles per bit; integer divide so TX and RX round identically.
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: free-running 0..DIV-1 counter, restarted on accept; bit_end marks count DIV-1.
// Latency: bit_end asserts DIV cycles after a restart. No backpressure.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits; parity bit when UART_TX_PARITY_EN is defined.
// Latency: start bit on the line the cycle after accept; frame is (1+8+P+STOP_BITS)*DIV cycles.
// Backpressure: tx_ready only in IDLE, so at least one idle cycle separates frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_t  state, state_nxt;
  logic [7:0] sh, sh_nxt;
  logic [2:0] idx, idx_nxt;
  logic       stop_idx, stop_nxt;
  logic       tx_nxt;
  logic       accept;
  logic       bit_end;

  assign tx_ready = (state == TX_IDLE);
  assign tx_busy  = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign tx_done  = (state == TX_STOP) && bit_end && (stop_idx == STOP_LAST);

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .bit_end (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = TX_PARITY;
  logic par_bit;

  // Parity comes from the byte as latched, so later tx_data changes cannot affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= (^tx_data) ^ (PARITY_ODD != 0);
    end
  end
`else
  localparam tx_state_t AFTER_DATA = TX_STOP;
  localparam int unused_parity_odd = PARITY_ODD;
`endif

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    idx_nxt   = idx;
    stop_nxt  = stop_idx;
    case (state)
      TX_IDLE: begin
        if (accept) begin
          state_nxt = TX_START;
          sh_nxt    = tx_data;
          idx_nxt   = 3'd0;
          stop_nxt  = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          sh_nxt  = {1'b0, sh[7:1]};
          idx_nxt = idx + 1'b1;
          if (idx == 3'd7) state_nxt = AFTER_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          if (stop_idx == STOP_LAST) state_nxt = TX_IDLE;
          else                       stop_nxt  = stop_idx + 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx itself can be a flop.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      TX_START:  tx_nxt = 1'b0;
      TX_DATA:   tx_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_nxt = par_bit;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      sh       <= 8'h00;
      idx      <= 3'd0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      sh       <= sh_nxt;
      idx      <= idx_nxt;
      stop_idx <= stop_nxt;
      tx       <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10: one 1-stop/even instance and one 2-stop/odd instance.
module tb_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS  = 1;
`else
  localparam int PBITS  = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] d0    = 8'h00;
  logic [7:0] d1    = 8'h00;
  logic [1:0] vld   = 2'b00;
  logic [1:0] rdy, txl, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int frame_len(input int stop);
    return (1 + 8 + PBITS + stop) * DIV;
  endfunction

  // Expected line level in sample k (k=1 is the cycle right after the accept edge).
  function automatic int exp_bit(input logic [7:0] b, input bit odd, input int k);
    int i;
    i = (k - 1) / DIV;
    if (i == 0) return 0;
    if (i <= 8) return int'(b[i-1]);
    if (PBITS == 1 && i == 9) return int'((^b) ^ odd);
    return 1;
  endfunction

  // Presents a byte at a negedge; returns at the negedge of the first frame cycle.
  task automatic send(input int s, input logic [7:0] b, input bit hold);
    int w = 0;
    while (!rdy[s] && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[s]) chk("ready_wait_timeout", 0, 1);
    if (s == 0) d0 = b; else d1 = b;
    vld[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) vld[s] = 1'b0;
  endtask

  task automatic check_frame(input int s, input logic [7:0] b, input int stop, input bit odd,
                             input string tag);
    int len;
    len = frame_len(stop);
    for (int k = 1; k <= len; k++) begin
      chk({tag, "_tx"},   int'(txl[s]),  exp_bit(b, odd, k));
      chk({tag, "_done"}, int'(done[s]), (k == len) ? 1 : 0);
      chk({tag, "_busy"}, int'(busy[s]), 1);
      @(negedge clk);
    end
    chk({tag, "_idle_tx"},    int'(txl[s]),  1);
    chk({tag, "_idle_ready"}, int'(rdy[s]),  1);
    chk({tag, "_idle_busy"},  int'(busy[s]), 0);
  endtask

  // Mid-bit sampling receiver for the 1-stop instance.
  task automatic rx_decode(output logic [7:0] got, output bit frame_ok);
    int len;
    len = frame_len(1);
    got = 8'h00;
    frame_ok = 1'b1;
    for (int k = 1; k <= len; k++) begin
      if ((k - 1) % DIV == DIV / 2) begin
        if ((k - 1) / DIV == 0 && txl[0] !== 1'b0) frame_ok = 1'b0;
        else if ((k - 1) / DIV >= 1 && (k - 1) / DIV <= 8) got[(k-1)/DIV - 1] = txl[0];
        else if ((k - 1) / DIV == len / DIV - 1 && txl[0] !== 1'b1) frame_ok = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  logic [7:0] lb_bytes [3];
  logic [7:0] rx_byte;
  bit         rx_ok;

  initial begin
    lb_bytes[0] = 8'hA5;
    lb_bytes[1] = 8'h00;
    lb_bytes[2] = 8'hFF;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx0",    int'(txl[0]),  1);
    chk("rst_ready0", int'(rdy[0]),  1);
    chk("rst_busy0",  int'(busy[0]), 0);
    chk("rst_done0",  int'(done[0]), 0);
    chk("rst_tx1",    int'(txl[1]),  1);
    chk("rst_ready1", int'(rdy[1]),  1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55: alternating data bits, done at sample 100, ready at 101
    send(0, 8'h55, 1'b0);
    check_frame(0, 8'h55, 1, 1'b0, "f55");

    // back-to-back bytes through a mid-bit sampling receiver
    for (int i = 0; i < 3; i++) begin
      send(0, lb_bytes[i], 1'b0);
      rx_decode(rx_byte, rx_ok);
      chk("lb_byte",  int'(rx_byte), int'(lb_bytes[i]));
      chk("lb_frame", int'(rx_ok), 1);
    end

    // valid held high: 0x3C then 0xC3, data changes mid-frame ignored
    send(0, 8'h3C, 1'b1);
    d0 = 8'hC3;
    check_frame(0, 8'h3C, 1, 1'b0, "hold1");
    @(negedge clk);
    vld[0] = 1'b0;
    d0 = 8'h00;
    check_frame(0, 8'hC3, 1, 1'b0, "hold2");
    repeat (3) @(negedge clk);
    chk("hold_no_third", int'(busy[0]), 0);

    // reset in sample 45 of a 0x0F frame
    send(0, 8'h0F, 1'b0);
    repeat (44) @(negedge clk);
    chk("mid_busy", int'(busy[0]), 1);
    chk("mid_tx",   int'(txl[0]),  1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx",    int'(txl[0]),  1);
    chk("rstmid_busy",  int'(busy[0]), 0);
    chk("rstmid_ready", int'(rdy[0]),  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h81, 1'b0);
    check_frame(0, 8'h81, 1, 1'b0, "f81");

    // two stop bits
    send(1, 8'hF0, 1'b0);
    check_frame(1, 8'hF0, 2, 1'b1, "stop2");

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0 (samples 91..100)
    send(0, 8'h07, 1'b0);
    repeat (94) @(negedge clk);
    chk("par_even_bit", int'(txl[0]), 1);
    repeat (15) @(negedge clk);
    chk("par_even_done", int'(done[0]), 1);
    @(negedge clk);
    chk("par_even_ready", int'(rdy[0]), 1);

    send(1, 8'h07, 1'b0);
    repeat (94) @(negedge clk);
    chk("par_odd_bit", int'(txl[1]), 0);
    repeat (25) @(negedge clk);
    chk("par_odd_done", int'(done[1]), 1);
    @(negedge clk);
    chk("par_odd_ready", int'(rdy[1]), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
